mbscore_alu_arbiter: RTL and testbench

Shares the single combinational MBScore ALU among NUM_REQ requesters (e.g. integer issue, branch compare, address generation). Each cycle it picks at most one eligible request by round-robin, drives the ALU operand and opcode inputs, and captures the ALU result into that requester's one-entry response buffer. Responses are returned on per-requester valid/ready channels with one-cycle latency.

---
 rtl/mbscore_alu_arbiter.sv | 104 ++++++++++
 tb/tb_mbscore_alu_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbscore_alu_arbiter.sv
// Round-robin share of one combinational ALU among NUM_REQ requesters, one-entry result buffer each.
// Latency: grant and ALU drive in the request cycle, result visible in resp_data one cycle later.
// Backpressure: a requester with a full buffer that is not draining this cycle is never granted.
module mbscore_alu_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
  output logic                          alu_start,
  output logic [DATA_WIDTH-1:0]         alu_in_a,
  output logic [DATA_WIDTH-1:0]         alu_in_b,
  output logic [OP_WIDTH-1:0]           alu_op_type,
  input  logic [DATA_WIDTH-1:0]         alu_out,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               any_grant;

  // ptr + k never reaches 2*NUM_REQ, so a single conditional subtract wraps it
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PTR_W'(s);
  endfunction

  assign elig = req_valid & (~resp_valid | resp_ready);

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(ptr, k);
      if (!found && elig[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    // Held in reset, nothing may be accepted even though req_valid is live
    any_grant = found & rst_n;
    if (any_grant) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign alu_start = any_grant;

  always_comb begin
    alu_in_a    = '0;
    alu_in_b    = '0;
    alu_op_type = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_in_a    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        alu_in_b    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        alu_op_type = req_op[i*OP_WIDTH +: OP_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_grant) begin
      ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Refill beats drain when both land on the same buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          resp_valid[i]                          <= 1'b1;
          resp_data[i*DATA_WIDTH +: DATA_WIDTH] <= alu_out;
        end else if (resp_ready[i] && resp_valid[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbscore_alu_arbiter.sv
// Table-driven bench for mbscore_alu_arbiter with a behavioural ALU and a result scoreboard.
module tb_mbscore_alu_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int OW = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_BAD = 4'hF;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N*OW-1:0] req_op;
  logic            alu_start;
  logic [DW-1:0]   alu_in_a;
  logic [DW-1:0]   alu_in_b;
  logic [OW-1:0]   alu_op_type;
  logic [DW-1:0]   alu_out;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [N*DW-1:0] resp_data;

  mbscore_alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_start(alu_start), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_op_type(alu_op_type), .alu_out(alu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared ALU; unknown opcodes return a recognisable pattern
  always_comb begin
    case (alu_op_type)
      OP_ADD:  alu_out = alu_in_a + alu_in_b;
      OP_SUB:  alu_out = alu_in_a - alu_in_b;
      OP_AND:  alu_out = alu_in_a & alu_in_b;
      OP_OR:   alu_out = alu_in_a | alu_in_b;
      OP_XOR:  alu_out = alu_in_a ^ alu_in_b;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  rr;
    logic [N-1:0]  g;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    logic [DW-1:0] res;
  } vec_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } sb_t;

  vec_t          vecs[21];
  sb_t           sbq[$];
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_data[N];
  int            total;
  int            bad;
  int            cur;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %h want %h", name, cur, act, exp);
    end
  endtask

  task automatic check_buffers();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      exp_data[e.idx] = e.data;
    end
    chk("resp_valid", DW'(resp_valid), DW'(exp_rv));
    for (int i = 0; i < N; i++)
      if (exp_rv[i]) chk($sformatf("resp_data[%0d]", i), resp_data[i*DW +: DW], exp_data[i]);
  endtask

  // Granted requester gets the table operands; everyone else carries random noise
  task automatic drive_ops(input logic [N-1:0] g, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [OW-1:0] op);
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
        req_op[i*OW +: OW] = op;
      end else begin
        req_a[i*DW +: DW]  = $urandom;
        req_b[i*DW +: DW]  = $urandom;
        req_op[i*OW +: OW] = OW'($urandom);
      end
    end
  endtask

  task automatic run_vec(input vec_t t);
    logic          gv;
    sb_t           e;
    @(negedge clk);
    req_valid  = t.v;
    resp_ready = t.rr;
    drive_ops(t.g, t.a, t.b, t.op);
    gv = |t.g;
    #1;
    chk("req_ready", DW'(req_ready), DW'(t.g));
    chk("alu_start", DW'(alu_start), DW'(gv));
    chk("alu_in_a", alu_in_a, gv ? t.a : '0);
    chk("alu_in_b", alu_in_b, gv ? t.b : '0);
    chk("alu_op_type", DW'(alu_op_type), gv ? DW'(t.op) : '0);
    for (int i = 0; i < N; i++)
      if (t.g[i]) begin
        e.idx  = i;
        e.data = t.res;
        sbq.push_back(e);
      end
    @(posedge clk);
    #1;
    exp_rv = t.g | (exp_rv & ~t.rr);
    check_buffers();
  endtask

  initial begin
    total = 0; bad = 0; cur = -1;
    exp_rv = '0;
    for (int i = 0; i < N; i++) exp_data[i] = '0;

    // v, rr, grant, a, b, op, result
    vecs[0]  = '{3'b010, 3'b111, 3'b010, 32'd5,       32'd7,      OP_ADD, 32'd12};
    vecs[1]  = '{3'b000, 3'b000, 3'b000, 32'd0,       32'd0,      OP_ADD, 32'd0};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = vecs[1];
    vecs[5]  = '{3'b111, 3'b111, 3'b100, 32'd100,     32'd1,      OP_SUB, 32'd99};
    vecs[6]  = '{3'b111, 3'b111, 3'b001, 32'h10,      32'h20,     OP_ADD, 32'h30};
    vecs[7]  = '{3'b111, 3'b111, 3'b010, 32'hFF00,    32'h0FF0,   OP_AND, 32'h0F00};
    vecs[8]  = '{3'b111, 3'b111, 3'b100, 32'hF000,    32'h000F,   OP_OR,  32'hF00F};
    vecs[9]  = '{3'b111, 3'b111, 3'b001, 32'hAAAA,    32'h5555,   OP_XOR, 32'hFFFF};
    vecs[10] = '{3'b111, 3'b111, 3'b010, 32'd0,       32'd1,      OP_SUB, 32'hFFFF_FFFF};
    vecs[11] = '{3'b111, 3'b111, 3'b100, 32'hFFFF_FFFF, 32'd1,    OP_ADD, 32'd0};
    vecs[12] = '{3'b100, 3'b111, 3'b100, 32'd9,       32'd4,      OP_SUB, 32'd5};
    vecs[13] = '{3'b100, 3'b111, 3'b100, 32'hF0,      32'hFF,     OP_XOR, 32'h0F};
    vecs[14] = '{3'b011, 3'b111, 3'b001, 32'd3,       32'd3,      OP_AND, 32'd3};
    vecs[15] = '{3'b001, 3'b110, 3'b000, 32'd0,       32'd0,      OP_ADD, 32'd0};
    vecs[16] = '{3'b111, 3'b110, 3'b010, 32'd1,       32'd2,      OP_OR,  32'd3};
    vecs[17] = '{3'b111, 3'b110, 3'b100, 32'd7,       32'd7,      OP_XOR, 32'd0};
    vecs[18] = '{3'b111, 3'b110, 3'b010, 32'd2,       32'd3,      OP_ADD, 32'd5};
    vecs[19] = '{3'b001, 3'b111, 3'b001, 32'd6,       32'd6,      OP_BAD, 32'hDEAD_BEEF};
    vecs[20] = '{3'b010, 3'b000, 3'b010, 32'd4,       32'd4,      OP_ADD, 32'd8};

    // Reset with live requests: nothing may be granted or issued
    rst_n = 1'b0;
    req_valid = 3'b111;
    resp_ready = 3'b111;
    drive_ops(3'b000, '0, '0, '0);
    #2;
    chk("rst req_ready", DW'(req_ready), '0);
    chk("rst alu_start", DW'(alu_start), '0);
    chk("rst alu_in_a", alu_in_a, '0);
    chk("rst resp_valid", DW'(resp_valid), '0);
    chk("rst resp_data", resp_data[DW-1:0] | resp_data[DW +: DW] | resp_data[2*DW +: DW], '0);
    req_valid = '0;
    resp_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 21; k++) begin
      cur = k;
      run_vec(vecs[k]);
    end

    // Buffers 0,1 full and stalled, ptr at 2: only requester 2 is eligible
    cur = 100;
    @(negedge clk);
    req_valid  = 3'b111;
    resp_ready = 3'b000;
    drive_ops(3'b111, 32'h11, 32'h22, OP_ADD);
    #1;
    chk("pre-rst req_ready", DW'(req_ready), 32'b100);
    chk("pre-rst resp_valid", DW'(resp_valid), 32'b011);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid-rst resp_valid", DW'(resp_valid), '0);
    chk("mid-rst req_ready", DW'(req_ready), '0);
    chk("mid-rst alu_start", DW'(alu_start), '0);
    chk("mid-rst alu_in_a", alu_in_a, '0);
    rst_n = 1'b1;
    sbq.delete();
    exp_rv = '0;
    #1;
    cur = 101;
    chk("post-rst req_ready", DW'(req_ready), 32'b001);
    chk("post-rst alu_in_a", alu_in_a, 32'h11);
    @(posedge clk);
    #1;
    chk("post-rst resp_valid", DW'(resp_valid), 32'b001);
    chk("post-rst resp_data[0]", resp_data[DW-1:0], 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
